// File: rtl/cla4_seq_adder_d_cla4.sv
`default_nettype none
// ============================================================================
//  Module      : d_cla4
//  Description : Dataflow 4-bit carry-look-ahead adder slice. All carries are
//                formed directly from generate/propagate terms and carry-in.
//  Revision    : 1.0 - initial release
// ============================================================================
module d_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [3:0] w_g;
    logic [3:0] w_p;
    logic [4:1] w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry is a flat sum-of-products, so none of them ripples
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign sum  = w_p ^ {w_c[3:1], cin};
    assign cout = w_c[4];

endmodule
`default_nettype wire

// File: rtl/cla4_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module      : cla4_seq_adder
//  Description : Multi-cycle WIDTH-bit adder. One 4-bit CLA slice is reused
//                for every nibble, least significant first, with the carry
//                held in a register between cycles. Valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla4_seq_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NIB  = WIDTH / 4;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
            $error("cla4_seq_adder: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [IDXW-1:0]  r_idx;
    logic             r_carry;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [3:0]       w_slice_sum;
    logic             w_slice_cout;
    logic             w_accept;
    logic             w_last;

    // A completing result in DONE frees the operand registers on the same edge
    assign in_ready  = ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready)) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == IDXW'(NIB - 1));
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN);
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    // Select the current nibble of each latched operand for the shared slice
    always_comb begin
        w_a_nib = 4'd0;
        w_b_nib = 4'd0;
        for (int n = 0; n < NIB; n++) begin
            if (r_idx == IDXW'(n)) begin
                w_a_nib = r_a[4*n +: 4];
                w_b_nib = r_b[4*n +: 4];
            end
        end
    end

    d_cla4 u_slice (
        .a    (w_a_nib),
        .b    (w_b_nib),
        .cin  (r_carry),
        .sum  (w_slice_sum),
        .cout (w_slice_cout)
    );

    // Next-state decode for IDLE -> RUN -> DONE -> (RUN | IDLE)
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_RUN;
            S_RUN:  if (w_last)   w_state_nxt = S_DONE;
            S_DONE: begin
                if (w_accept)       w_state_nxt = S_RUN;
                else if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Operand capture, per-nibble write-back and final flag generation
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            for (int n = 0; n < NIB; n++) begin
                if (r_idx == IDXW'(n)) r_sum[4*n +: 4] <= w_slice_sum;
            end
            r_carry <= w_slice_cout;
            if (w_last) begin
                // Parking idx at zero keeps it inside 0..NIB-1 for any NIB
                r_idx  <= '0;
                r_cout <= w_slice_cout;
                r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_slice_sum[3] != r_a[WIDTH-1]);
            end else begin
                r_idx  <= r_idx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cla4_seq_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cla4_seq_adder
//  Description : Scoreboard bench for cla4_seq_adder at WIDTH = 4, 16, 32.
//                Expected results come from signed/unsigned integer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla4_seq_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_v    [3];
    logic        in_rdy  [3];
    logic        out_v   [3];
    logic        out_rdy [3];
    logic        busy_o  [3];
    logic        cout_o  [3];
    logic        ovf_o   [3];
    logic        cin_in  [3];
    logic [31:0] a_in    [3];
    logic [31:0] b_in    [3];
    logic [31:0] sum_o   [3];
    logic [3:0]  s4;
    logic [15:0] s16;
    logic [31:0] s32;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n_checks = 0;
    int n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cla4_seq_adder #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(in_v[0]), .in_ready(in_rdy[0]),
        .a(a_in[0][3:0]), .b(b_in[0][3:0]), .cin(cin_in[0]),
        .out_valid(out_v[0]), .out_ready(out_rdy[0]), .sum(s4),
        .cout(cout_o[0]), .ovf(ovf_o[0]), .busy(busy_o[0]));

    cla4_seq_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(in_v[1]), .in_ready(in_rdy[1]),
        .a(a_in[1][15:0]), .b(b_in[1][15:0]), .cin(cin_in[1]),
        .out_valid(out_v[1]), .out_ready(out_rdy[1]), .sum(s16),
        .cout(cout_o[1]), .ovf(ovf_o[1]), .busy(busy_o[1]));

    cla4_seq_adder #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst(rst), .in_valid(in_v[2]), .in_ready(in_rdy[2]),
        .a(a_in[2]), .b(b_in[2]), .cin(cin_in[2]),
        .out_valid(out_v[2]), .out_ready(out_rdy[2]), .sum(s32),
        .cout(cout_o[2]), .ovf(ovf_o[2]), .busy(busy_o[2]));

    assign sum_o[0] = {28'd0, s4};
    assign sum_o[1] = {16'd0, s16};
    assign sum_o[2] = s32;

    function automatic int width_of(int k);
        return (k == 0) ? 4 : (k == 1) ? 16 : 32;
    endfunction

    // Reference: unsigned total for sum/cout, signed range test for overflow
    function automatic exp_t model(int w, logic [31:0] av, logic [31:0] bv, logic cv);
        exp_t        e;
        longint      ua, ub, tot, sa, sb, st, lim;
        ua  = longint'(av) & ((64'sd1 <<< w) - 1);
        ub  = longint'(bv) & ((64'sd1 <<< w) - 1);
        tot = ua + ub + longint'(cv);
        e.sum  = 32'(tot & ((64'sd1 <<< w) - 1));
        e.cout = (tot >= (64'sd1 <<< w));
        lim = 64'sd1 <<< (w - 1);
        sa  = (ua >= lim) ? ua - (64'sd1 <<< w) : ua;
        sb  = (ub >= lim) ? ub - (64'sd1 <<< w) : ub;
        st  = sa + sb + longint'(cv);
        e.ovf = (st >= lim) || (st < -lim);
        return e;
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, req);
    endtask

    task automatic fail(string nm);
        n_checks++;
        $display("FAIL %s", nm);
    endtask

    task automatic push(int k, exp_t e);
        if (k == 0)      q0.push_back(e);
        else if (k == 1) q1.push_back(e);
        else             q2.push_back(e);
    endtask

    function automatic int qsize(int k);
        return (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    endfunction

    function automatic exp_t qpop(int k);
        return (k == 0) ? q0.pop_front() : (k == 1) ? q1.pop_front() : q2.pop_front();
    endfunction

    // Monitor: a result is consumed when out_valid and out_ready meet
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 3; k++) begin
                if (out_v[k] && out_rdy[k]) begin
                    if (qsize(k) == 0) begin
                        fail($sformatf("w%0d unexpected result sum=%0h", width_of(k), sum_o[k]));
                    end else begin
                        exp_t e;
                        e = qpop(k);
                        chk($sformatf("w%0d sum", width_of(k)),  64'(sum_o[k]),  64'(e.sum));
                        chk($sformatf("w%0d cout", width_of(k)), 64'(cout_o[k]), 64'(e.cout));
                        chk($sformatf("w%0d ovf", width_of(k)),  64'(ovf_o[k]),  64'(e.ovf));
                    end
                end
            end
        end
    end

    // Present operands until accepted; expected result is queued at accept
    task automatic send(int k, logic [31:0] av, logic [31:0] bv, logic cv, bit bp);
        int  t;
        bit  got;
        t   = 0;
        got = 0;
        in_v[k] = 1'b1; a_in[k] = av; b_in[k] = bv; cin_in[k] = cv;
        while (!got && t < 300) begin
            if (bp) out_rdy[k] = ($urandom_range(0, 3) != 0);
            #1;
            if (in_rdy[k]) got = 1;
            else begin
                @(posedge clk); #1;
                t++;
            end
        end
        if (!got) begin
            fail($sformatf("w%0d in_ready timeout", width_of(k)));
            in_v[k] = 1'b0;
            return;
        end
        push(k, model(width_of(k), av, bv, cv));
        @(posedge clk); #1;
        in_v[k] = 1'b0;
    endtask

    task automatic wait_valid(int k, output int lat);
        lat = 0;
        while (!out_v[k] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_v[k]) fail($sformatf("w%0d out_valid timeout", width_of(k)));
    endtask

    task automatic run_random(int k, int n);
        int w;
        logic [31:0] msk, av, bv;
        w   = width_of(k);
        msk = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
        for (int i = 0; i < n; i++) begin
            av = $urandom() & msk;
            bv = $urandom() & msk;
            if ($urandom_range(0, 15) == 0) av = msk;
            if ($urandom_range(0, 15) == 0) bv = msk ^ av;
            repeat ($urandom_range(0, 2)) begin
                out_rdy[k] = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
            send(k, av, bv, 1'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        int lat;
        int t;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_v[k] = 1'b0; out_rdy[k] = 1'b1; a_in[k] = '0; b_in[k] = '0; cin_in[k] = 1'b0;
        end
        @(posedge clk); #1;
        chk("in_ready during rst", 64'(in_rdy[1]), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("w%0d reset out_valid", width_of(k)), 64'(out_v[k]),  64'd0);
            chk($sformatf("w%0d reset busy", width_of(k)),      64'(busy_o[k]), 64'd0);
            chk($sformatf("w%0d reset sum", width_of(k)),       64'(sum_o[k]),  64'd0);
            chk($sformatf("w%0d reset in_ready", width_of(k)),  64'(in_rdy[k]), 64'd1);
        end

        // Basic add with latency check
        send(1, 32'h0005, 32'h0006, 1'b1, 1'b0);
        chk("busy after accept", 64'(busy_o[1]), 64'd1);
        wait_valid(1, lat);
        chk("latency 5+6+1", 64'(lat), 64'd4);

        // Full ripple, then signed overflow both directions
        send(1, 32'hFFFF, 32'h0000, 1'b1, 1'b0);
        wait_valid(1, lat);
        send(1, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
        wait_valid(1, lat);
        send(1, 32'h8000, 32'h8000, 1'b0, 1'b0);
        wait_valid(1, lat);
        @(posedge clk); #1;

        // Backpressure hold, then same-edge complete and accept
        out_rdy[1] = 1'b0;
        send(1, 32'h0003, 32'h0004, 1'b0, 1'b0);
        wait_valid(1, lat);
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", 64'(out_v[1]),  64'd1);
            chk("bp in_ready",  64'(in_rdy[1]), 64'd0);
            chk("bp sum",       64'(sum_o[1]),  64'h0007);
            @(posedge clk); #1;
        end
        out_rdy[1] = 1'b1;
        send(1, 32'h1234, 32'h1111, 1'b0, 1'b0);
        chk("b2b out_valid fell", 64'(out_v[1]),  64'd0);
        chk("b2b busy",           64'(busy_o[1]), 64'd1);
        wait_valid(1, lat);
        chk("b2b latency", 64'(lat), 64'd4);
        @(posedge clk); #1;

        // Reset mid-RUN at idx 2 discards the operation
        send(1, 32'h1111, 32'h2222, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(q1.pop_back());
        #1;
        chk("midrun rst out_valid", 64'(out_v[1]),  64'd0);
        chk("midrun rst busy",      64'(busy_o[1]), 64'd0);
        chk("midrun rst sum",       64'(sum_o[1]),  64'd0);
        chk("midrun rst cout",      64'(cout_o[1]), 64'd0);
        send(1, 32'h0005, 32'h0006, 1'b0, 1'b0);
        wait_valid(1, lat);
        chk("post rst latency", 64'(lat), 64'd4);
        @(posedge clk); #1;

        // in_valid pulses during RUN must not disturb the running add
        send(1, 32'h0F0F, 32'h00F1, 1'b1, 1'b0);
        in_v[1] = 1'b1; a_in[1] = 32'hAAAA; b_in[1] = 32'h5555;
        #1;
        chk("run in_ready", 64'(in_rdy[1]), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_v[1] = 1'b0;
        wait_valid(1, lat);
        @(posedge clk); #1;

        // Randomised sweeps on all three widths with random backpressure
        fork
            run_random(0, 1000);
            run_random(1, 1000);
            run_random(2, 1000);
        join

        for (int k = 0; k < 3; k++) out_rdy[k] = 1'b1;
        t = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        chk("w4 drained",  64'(q0.size()), 64'd0);
        chk("w16 drained", 64'(q1.size()), 64'd0);
        chk("w32 drained", 64'(q2.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
